// File: rtl/result_encoder.sv
// ASCII result formatter for the UART calculator: serialises one ALU result as
// decimal (double-dabble), hex, "ERR" or "E", then a line ending. `ENC_CRLF_EN selects CR LF vs LF.
module result_encoder #(
  parameter int DATA_W     = 32,
  parameter int DEC_DIGITS = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] result,
  input  logic [3:0]        dtype,
  input  logic              err,
  output logic              busy,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              enc_done
);
  localparam int BW = 4*DEC_DIGITS;
  localparam int NH = DATA_W/4;
  localparam int IW = $clog2(DEC_DIGITS);
  localparam int HW = $clog2(NH);
  localparam int CW = $clog2(DATA_W);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CONV, S_EMIT, S_EOL, S_DONE} state_t;
  typedef enum logic [1:0] {M_DEC, M_HEX, M_ERR, M_BAD} mode_t;

  state_t            state_q, state_d;
  mode_t             mode_q;
  logic              sgn_q, neg_q, lead_q;
  logic [DATA_W-1:0] res_q, mag_q;
  logic [BW-1:0]     bcd_q, bcd_adj;
  logic [CW-1:0]     cnt_q;
  logic [IW-1:0]     dig_q, first_nz, cur_dig;
  logic [3:0]        bcd_dig [DEC_DIGITS];
  logic [3:0]        hex_nib [NH];
  logic [3:0]        dnib, hnib;
  logic              xfer, emit_last, eol_last;
  logic [7:0]        eol_byte;

  always_comb begin
    for (int i = 0; i < DEC_DIGITS; i++) begin
      bcd_dig[i] = bcd_q[4*i +: 4];
      bcd_adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
    end
    for (int i = 0; i < NH; i++) hex_nib[i] = res_q[4*i +: 4];
  end

  // Highest nonzero digit; an all-zero value yields index 0 so "0" is printed.
  always_comb begin
    first_nz = '0;
    for (int i = 0; i < DEC_DIGITS; i++)
      if (bcd_dig[i] != 4'd0) first_nz = IW'(i);
  end

  assign cur_dig = lead_q ? first_nz : dig_q;
  assign dnib    = bcd_dig[cur_dig];
  assign hnib    = hex_nib[dig_q[HW-1:0]];
  assign xfer    = tx_valid && tx_ready;

  always_comb begin
    case (mode_q)
      M_DEC:   emit_last = !neg_q && (cur_dig == '0);
      M_HEX,
      M_ERR:   emit_last = (dig_q == '0);
      default: emit_last = 1'b1;
    endcase
  end

`ifdef ENC_CRLF_EN
  logic eol_q;
  assign eol_last = eol_q;
  assign eol_byte = eol_q ? 8'h0A : 8'h0D;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          eol_q <= 1'b0;
    else if (state_q == S_LOAD)       eol_q <= 1'b0;
    else if (state_q == S_EOL && xfer) eol_q <= 1'b1;
  end
`else
  assign eol_last = 1'b1;
  assign eol_byte = 8'h0A;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_LOAD;
      S_LOAD:  state_d = (mode_q == M_DEC) ? S_CONV : S_EMIT;
      S_CONV:  if (cnt_q == CW'(DATA_W-1)) state_d = S_EMIT;
      S_EMIT:  if (xfer && emit_last) state_d = S_EOL;
      S_EOL:   if (xfer && eol_last) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_q != S_IDLE);
    tx_valid = (state_q == S_EMIT) || (state_q == S_EOL);
    enc_done = (state_q == S_DONE);
    tx_data  = 8'h00;
    if (state_q == S_EMIT) begin
      case (mode_q)
        M_DEC:   tx_data = neg_q ? 8'h2D : 8'h30 + {4'h0, dnib};
        M_HEX:   tx_data = (hnib < 4'd10) ? 8'h30 + {4'h0, hnib} : 8'h37 + {4'h0, hnib};
        M_ERR:   tx_data = (dig_q == IW'(2)) ? 8'h45 : 8'h52;
        default: tx_data = 8'h45;
      endcase
    end else if (state_q == S_EOL) begin
      tx_data = eol_byte;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q <= M_DEC;
      sgn_q  <= 1'b0;
      neg_q  <= 1'b0;
      lead_q <= 1'b0;
      res_q  <= '0;
      mag_q  <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      dig_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (start) begin
          res_q <= result;
          sgn_q <= (dtype == 4'h2);
          if (err)                               mode_q <= M_ERR;
          else if (dtype == 4'h1 || dtype == 4'h2) mode_q <= M_DEC;
          else if (dtype == 4'h3)                mode_q <= M_HEX;
          else                                   mode_q <= M_BAD;
        end
        S_LOAD: begin
          neg_q  <= (mode_q == M_DEC) && sgn_q && res_q[DATA_W-1];
          mag_q  <= (sgn_q && res_q[DATA_W-1]) ? -res_q : res_q;
          bcd_q  <= '0;
          cnt_q  <= '0;
          lead_q <= 1'b1;
          case (mode_q)
            M_HEX:   dig_q <= IW'(NH-1);
            M_ERR:   dig_q <= IW'(2);
            default: dig_q <= IW'(DEC_DIGITS-1);
          endcase
        end
        S_CONV: begin
          {bcd_q, mag_q} <= {bcd_adj[BW-2:0], mag_q, 1'b0};
          cnt_q          <= cnt_q + 1'b1;
        end
        S_EMIT: if (xfer) begin
          if (mode_q != M_DEC) dig_q <= dig_q - 1'b1;
          else if (neg_q)      neg_q <= 1'b0;
          else begin
            lead_q <= 1'b0;
            dig_q  <= cur_dig - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/result_encoder.md
Name: result_encoder

Overview:
Transmit-side formatter for the UART calculator. Takes one calculation result plus its data type from the ALU and serialises it as ASCII bytes, terminated by a line ending, toward the UART transmitter. It is the output-direction counterpart of the command decoder, which parses ASCII bytes into operator and operands. Decimal conversion uses a sequential double-dabble engine.

Parameters:
DATA_W, 32, result width in bits; legal values 16 or 32.
DEC_DIGITS, 10, number of BCD digits held by the converter; 5 for DATA_W=16, 10 for DATA_W=32.

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  one-cycle request to format the values on result/dtype/err
result  input  DATA_W  value to print, two's complement
dtype  input  4  format: 4'h1 unsigned decimal, 4'h2 signed decimal, 4'h3 uppercase hex; any other code prints "E"
err  input  1  when high at start, prints "ERR" (e.g. divide-by-zero); result and dtype ignored
busy  output  1  high from the cycle after start is accepted until enc_done
tx_data  output  8  ASCII byte to the UART TX
tx_valid  output  1  tx_data is valid
tx_ready  input  1  UART TX accepts tx_data this cycle
enc_done  output  1  one-cycle pulse in the cycle after the final line-ending byte is accepted

Behaviour:
- Reset: busy=0, tx_valid=0, tx_data=8'h00, enc_done=0; FSM=IDLE; BCD register cleared. Reset asserted mid-operation aborts immediately: tx_valid drops asynchronously, the partial line is not completed, and no enc_done is issued.
- start is sampled only in IDLE; start while busy is ignored, with no queuing.
- On accept, result, dtype and err are registered; the inputs may change afterwards.
- FSM: IDLE -> LOAD -> (CONV | EMIT) -> EOL -> DONE -> IDLE.
  - LOAD (1 cycle): compute the magnitude. In signed mode with result[DATA_W-1]=1, magnitude = -result (so 0x80000000 prints 2147483648) and neg_flag=1.
  - CONV: decimal modes only; exactly DATA_W double-dabble iterations, one per cycle (add 3 to each BCD nibble >=5, then shift left).
  - EMIT:
    - Decimal: if neg_flag, send '-' first. Leading zeros are suppressed and the first nonzero digit index is found combinationally. A value of 0 prints the single byte '0'.
    - Hex: all DATA_W/4 nibbles, MSB first, no suppression, characters '0'-'9' and 'A'-'F'. Hex skips CONV.
    - err=1: 'E','R','R'.
    - Invalid dtype: 'E'.
  - EOL: line-ending bytes (see Optional Feature).
  - DONE: enc_done=1 for one cycle, busy=0 from the next cycle.
- Latency with tx_ready held high:
  - Decimal: first tx_valid in cycle DATA_W+2 after the start cycle.
  - Hex, err or invalid dtype: cycle 2.
  - Subsequent bytes follow back-to-back, one per cycle.
- Handshake: a byte transfers when tx_valid && tx_ready. While tx_valid=1 and tx_ready=0, tx_data must hold stable and tx_valid must not drop. tx_ready asserted while tx_valid=0 has no effect.
- enc_done and tx_valid are never high in the same cycle.

Optional Feature:
Macro ENC_CRLF_EN.
- Defined: line ending is 8'h0D then 8'h0A.
- Undefined: line ending is 8'h0A only.
- Byte counts in the test plan assume the macro is defined.

Test Plan:
1. dtype=1, result=6912 (1234+5678), tx_ready=1 -> bytes 36 39 31 32 0D 0A. First tx_valid at cycle 34, enc_done one cycle after 0A.
2. dtype=2, result=32'hFFFFEEA4 (-4444) -> bytes 2D 34 34 34 34 0D 0A.
3. dtype=1, result=0 -> bytes 30 0D 0A. Also dtype=2, result=32'h80000000 -> "-2147483648" CR LF.
4. dtype=3, result=32'h0000BEEF -> "0000BEEF" 0D 0A, first byte at cycle 2. Also err=1 -> 45 52 52 0D 0A.
5. dtype=1, result=32'hFFFFFFFF, tx_ready toggling 1/0 every cycle -> "4294967295" CR LF. tx_data stable while stalled. A second start pulsed mid-stream is ignored, with exactly one enc_done.
6. Assert rst during the 3rd byte of case 1 -> tx_valid=0 and busy=0 the same cycle. A fresh start after release prints case 1 correctly.
